// File: rtl/band_serializer_if.sv
// Bus between the band serializer and the downstream band register bank.
// It carries the frame request, the three parallel band samples and the
// serialized word stream with its valid/ready handshake.
interface band_serializer_if #(
  parameter int width = 25
);
  logic             start;
  logic [width-1:0] Entrada1;
  logic [width-1:0] Entrada2;
  logic [width-1:0] Entrada3;
  logic             ready;
  logic [width-1:0] Salida;
  logic [1:0]       Salida_Contador;
  logic             valid;
  logic [width-1:0] Suma;
  logic             suma_valid;
  logic             busy;

  // Serializer side: takes samples and ready, drives the stream.
  modport master (
    input  start, Entrada1, Entrada2, Entrada3, ready,
    output Salida, Salida_Contador, valid, Suma, suma_valid, busy
  );

  // Requester / downstream side.
  modport slave (
    output start, Entrada1, Entrada2, Entrada3, ready,
    input  Salida, Salida_Contador, valid, Suma, suma_valid, busy
  );
endinterface

// File: rtl/band_serializer.sv
// Band serializer: captures low/mid/high band samples on start and sends
// them one per valid/ready transfer, tagged with a 2-bit band index. A
// saturated signed sum of the three bands is published once per frame.
module band_serializer #(
  parameter int width = 25
) (
  input  logic              clk,
  input  logic              reset,
  band_serializer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  // Saturation bounds expressed in the widened (width+2) sum domain.
  localparam logic signed [width+1:0] SAT_MAX = {3'b000, {(width-1){1'b1}}};
  localparam logic signed [width+1:0] SAT_MIN = {3'b111, {(width-1){1'b0}}};

  state_t                   state_q;
  logic [1:0]               idx_q;
  logic [width-1:0]         cap_q [3];
  logic signed [width-1:0]  sum_q;
  logic signed [width-1:0]  sum_d;
  logic signed [width+1:0]  sum_wide;
  logic [width-1:0]         salida_q;
  logic                     valid_q;
  logic [width-1:0]         suma_q;
  logic                     suma_valid_q;
  logic                     busy_q;

  // Saturated sum of the incoming samples, latched together with them at capture.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    sum_wide = {{2{bus.Entrada1[width-1]}}, bus.Entrada1}
             + {{2{bus.Entrada2[width-1]}}, bus.Entrada2}
             + {{2{bus.Entrada3[width-1]}}, bus.Entrada3};
    sum_d    = sum_wide[width-1:0];
    if (sum_wide > SAT_MAX) begin
      sum_d = SAT_MAX[width-1:0];
    end else if (sum_wide < SAT_MIN) begin
      sum_d = SAT_MIN[width-1:0];
    end
  end

  // Frame FSM with all outputs registered; ready/start only steer next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the capture registers are a tiny array with a defined reset value, so they are cleared here like plain flops.
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cap_q[0]     <= '0;
      cap_q[1]     <= '0;
      cap_q[2]     <= '0;
      sum_q        <= '0;
      salida_q     <= '0;
      valid_q      <= 1'b0;
      suma_q       <= '0;
      suma_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      suma_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cap_q[0] <= bus.Entrada1;
            cap_q[1] <= bus.Entrada2;
            cap_q[2] <= bus.Entrada3;
            sum_q    <= sum_d;
            idx_q    <= 2'd0;
            salida_q <= bus.Entrada1;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (idx_q == 2'd3) begin
            // Index 11 is never produced; recover cleanly if it appears.
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (valid_q && bus.ready) begin
            case (idx_q)
              2'd0: begin
                idx_q    <= 2'd1;
                salida_q <= cap_q[1];
              end
              2'd1: begin
                idx_q    <= 2'd2;
                salida_q <= cap_q[2];
              end
              default: begin
                valid_q      <= 1'b0;
                suma_q       <= sum_q;
                suma_valid_q <= 1'b1;
                state_q      <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          // start here is deliberately dropped, not queued.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          idx_q   <= 2'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Salida          = salida_q;
  assign bus.Salida_Contador = idx_q;
  assign bus.valid           = valid_q;
  assign bus.Suma            = suma_q;
  assign bus.suma_valid      = suma_valid_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_band_serializer.sv
// Testbench for band_serializer: table of full frames with ready held high,
// plus hand-written sequences for stalls, ignored starts, input changes
// after capture and an asynchronous reset in the middle of a frame.
module tb_band_serializer;

  localparam int W    = 25;
  localparam int SMAX = 16777215;
  localparam int SMIN = -16777216;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  band_serializer_if #(.width(W)) bus ();

  band_serializer #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e1;
    int e2;
    int e3;
    int exp_sum;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input int e1, input int e2, input int e3);
    bus.Entrada1 = W'(e1);
    bus.Entrada2 = W'(e2);
    bus.Entrada3 = W'(e3);
  endtask

  task automatic check_word(input string tag, input int idx, input int data);
    check({tag, " valid"}, int'(bus.valid), 1);
    check({tag, " index"}, int'(bus.Salida_Contador), idx);
    check({tag, " data"}, $signed(bus.Salida), data);
    check({tag, " busy"}, int'(bus.busy), 1);
  endtask

  // Full frame with ready high; entered and left in IDLE right after an edge.
  task automatic run_frame(input string tag, input int e1, input int e2, input int e3,
                           input int exp_sum);
    set_inputs(e1, e2, e3);
    bus.ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_word({tag, " w0"}, 0, e1);
    tick();
    check_word({tag, " w1"}, 1, e2);
    tick();
    check_word({tag, " w2"}, 2, e3);
    tick();
    check({tag, " done valid"}, int'(bus.valid), 0);
    check({tag, " done suma_valid"}, int'(bus.suma_valid), 1);
    check({tag, " done Suma"}, $signed(bus.Suma), exp_sum);
    check({tag, " done busy"}, int'(bus.busy), 1);
    tick();
    check({tag, " idle suma_valid"}, int'(bus.suma_valid), 0);
    check({tag, " idle busy"}, int'(bus.busy), 0);
    check({tag, " idle Suma held"}, $signed(bus.Suma), exp_sum);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{5, -3, 7, 9};
    vecs[1] = '{SMAX, SMAX, SMAX, SMAX};
    vecs[2] = '{SMIN, SMIN, SMIN, SMIN};
    vecs[3] = '{0, 0, 0, 0};
    vecs[4] = '{SMAX, 1, 0, SMAX};
    vecs[5] = '{8388608, 8388608, -1, SMAX};
    vecs[6] = '{SMIN, 0, -1, SMIN};
    vecs[7] = '{-1, -1, -1, -3};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.ready = 1'b0;
    set_inputs(0, 0, 0);
    tick();
    tick();
    check("reset Salida", $signed(bus.Salida), 0);
    check("reset index", int'(bus.Salida_Contador), 0);
    check("reset valid", int'(bus.valid), 0);
    check("reset Suma", $signed(bus.Suma), 0);
    check("reset suma_valid", int'(bus.suma_valid), 0);
    check("reset busy", int'(bus.busy), 0);
    #3 reset = 1'b0;
    tick();
    check("post-reset idle valid", int'(bus.valid), 0);

    // Back-to-back frames, each start at the minimum 5-cycle period.
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].exp_sum);
    end

    // ready low for two cycles while index=01.
    set_inputs(5, -3, 7);
    bus.ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_word("stall w0", 0, 5);
    tick();
    check_word("stall w1 first", 1, -3);
    bus.ready = 1'b0;
    tick();
    check_word("stall w1 hold1", 1, -3);
    tick();
    check_word("stall w1 hold2", 1, -3);
    bus.ready = 1'b1;
    n = 4;
    while (!bus.suma_valid && n < 12) begin
      tick();
      n++;
    end
    check("stall done latency", n, 6);
    check("stall Suma", $signed(bus.Suma), 9);
    tick();
    check("stall idle busy", int'(bus.busy), 0);

    // start held high through SEND and DONE: ignored, then accepted in IDLE.
    set_inputs(1, 2, 3);
    bus.start = 1'b1;
    tick();
    check_word("ign w0", 0, 1);
    tick();
    check_word("ign w1", 1, 2);
    tick();
    check_word("ign w2", 2, 3);
    tick();
    check("ign done suma_valid", int'(bus.suma_valid), 1);
    check("ign done Suma", $signed(bus.Suma), 6);
    check("ign done valid", int'(bus.valid), 0);
    set_inputs(100, 200, 300);
    tick();
    check("ign idle valid", int'(bus.valid), 0);
    check("ign idle busy", int'(bus.busy), 0);
    tick();
    bus.start = 1'b0;
    check_word("ign new w0", 0, 100);
    tick();
    check_word("ign new w1", 1, 200);
    tick();
    check_word("ign new w2", 2, 300);
    tick();
    check("ign new Suma", $signed(bus.Suma), 600);
    tick();
    check("ign new idle busy", int'(bus.busy), 0);

    // Inputs zeroed right after capture do not affect the frame.
    set_inputs(11, -22, 33);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    set_inputs(0, 0, 0);
    check_word("cap w0", 0, 11);
    tick();
    check_word("cap w1", 1, -22);
    tick();
    check_word("cap w2", 2, 33);
    tick();
    check("cap Suma", $signed(bus.Suma), 22);
    check("cap suma_valid", int'(bus.suma_valid), 1);
    tick();

    // Asynchronous reset while index=01.
    set_inputs(5, -3, 7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_word("rst pre", 1, -3);
    #2 reset = 1'b1;
    #1;
    check("rst Salida", $signed(bus.Salida), 0);
    check("rst index", int'(bus.Salida_Contador), 0);
    check("rst valid", int'(bus.valid), 0);
    check("rst Suma", $signed(bus.Suma), 0);
    check("rst suma_valid", int'(bus.suma_valid), 0);
    check("rst busy", int'(bus.busy), 0);
    tick();
    check("rst hold suma_valid", int'(bus.suma_valid), 0);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst after%0d suma_valid", i), int'(bus.suma_valid), 0);
      check($sformatf("rst after%0d Suma", i), $signed(bus.Suma), 0);
      check($sformatf("rst after%0d valid", i), int'(bus.valid), 0);
    end
    run_frame("post-rst", 5, -3, 7, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/band_serializer.md
# band_serializer

Transmit-side counterpart of the band decoder/register bank in the recursive filter path. It captures the three parallel band samples (low, mid, high) on a start strobe and sends them one per transfer on a single shared bus. The bus carries a 2-bit band index and a valid/ready handshake, so the downstream band register bank can load each band from one stream. It also produces a saturated signed sum of the three bands once per frame, for the recombined filter output.

## Interface
- width, 25, sample width in bits, two's-complement signed
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  frame request; sampled only in IDLE
- Entrada1  input  width  low band sample
- Entrada2  input  width  mid band sample
- Entrada3  input  width  high band sample
- ready  input  1  downstream accepts current word when high together with valid
- Salida  output  width  serialized band sample
- Salida_Contador  output  2  band index of Salida: 00 low, 01 mid, 10 high
- valid  output  1  Salida/Salida_Contador hold a word
- Suma  output  width  saturated Entrada1+Entrada2+Entrada3 of the last frame
- suma_valid  output  1  one-cycle pulse when Suma updates
- busy  output  1  frame in progress (SEND or DONE)

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - On start=1: capture Entrada1..3 into internal registers, set index=00, go to SEND.
  - The saturated sum is computed from the captured values in the same edge, into an internal register.
- SEND:
  - valid=1; Salida = captured[index]; Salida_Contador = index.
  - On valid&&ready: if index<10, index+1 and stay in SEND; if index=10, go to DONE.
  - ready low holds Salida and Salida_Contador stable with valid held high.
- DONE, one cycle:
  - valid=0; Suma loads the computed sum; suma_valid=1; go to IDLE.
- Index never takes value 11. Illegal FSM or index encodings recover to IDLE on the next edge.
- start outside IDLE is ignored, not queued, including start in the DONE cycle.
- Inputs are not observed after capture; changing Entrada1..3 mid-frame does not affect the frame.
- Sum arithmetic:
  - Sign-extend each input to width+2 bits and add.
  - If the result is > 2^(width-1)-1, output 2^(width-1)-1.
  - If the result is < -2^(width-1), output -2^(width-1).
  - Otherwise output the truncated result.
- Suma holds its value between frames.

## Timing
- Reset values: Salida=0, Salida_Contador=00, valid=0, Suma=0, suma_valid=0, busy=0, FSM=IDLE, captured registers=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously; no partial Suma update.
- Start accepted at edge t: valid=1 with index 00 visible after edge t; busy=1 from edge t.
- With ready held high:
  - words on cycles t+1, t+2, t+3;
  - DONE on cycle t+4, with suma_valid=1 and Suma updated;
  - IDLE from edge t+5.
- Minimum frame period is 5 cycles; a start at cycle t+5 is accepted.
- Each ready=0 cycle during SEND adds exactly one cycle of latency.
- busy=0 only in IDLE.
- All outputs are registered; no combinational path from ready or start to any output.

## Test plan
- Reset, then start with E1=5, E2=-3, E3=7, ready=1 → Salida 5/00, -3/01, 7/10 on three consecutive cycles; next cycle suma_valid=1, Suma=9; busy falls the cycle after.
- Same frame with ready=0 for 2 cycles while index=01 → Salida=-3 and Salida_Contador=01 held with valid=1 for 3 cycles; Suma=9 still arrives, 2 cycles later than the previous case.
- width=25, E1=E2=E3=16777215 → Suma=16777215; E1=E2=E3=-16777216 → Suma=-16777216.
- Pulse start during SEND and again during DONE → both ignored, exactly three words sent; a start one cycle after DONE begins a new frame.
- Change Entrada1..3 to 0 on the cycle after capture → serialized words and Suma reflect the captured values.
- Assert reset while index=01 → all outputs 0 immediately, suma_valid never pulses, Suma stays at its reset value 0; a start after reset release runs a clean frame.
